mem_port_arbiter: RTL

//  Shares one single-ported memory between the core's instruction-fetch port and its load/store port.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/load-store requesters, the port arbiter and the shared memory.
// The slave modport is the arbiter's view. The master modport is the surrounding core/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              err;
    logic              busy;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, err, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, err, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data has priority, fetch starvation is bounded, and an optional timeout aborts hung accesses.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SRV_I = 2'd1,
        SRV_D = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int          SW    = $clog2(STARVE_LIMIT + 1);
    localparam int          TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t            state;
    state_t            state_next;

    logic [SW-1:0]     starve_cnt;
    logic [TW-1:0]     wait_cnt;
    logic              served_d;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              i_ack_r;
    logic              d_ack_r;
    logic              err_r;
    logic              busy_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    logic              starve_max;
    logic              force_i;
    logic              grant_i;
    logic              grant_d;
    logic              done;
    logic              abort;
    logic              in_srv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        starve_max = (starve_cnt == SW'(STARVE_LIMIT));
        force_i    = bus.i_req && starve_max;
        in_srv     = (state == SRV_I) || (state == SRV_D);

        case (state)
            IDLE: begin
                if (bus.d_req && !force_i) begin
                    state_next = SRV_D;
                    grant_d    = 1'b1;
                end else if (bus.i_req) begin
                    state_next = SRV_I;
                    grant_i    = 1'b1;
                end
            end
            SRV_I, SRV_D: begin
                // A ready arriving on the expiry cycle still counts as a normal completion.
                if (bus.mem_ready) begin
                    done       = 1'b1;
                    state_next = ACK;
                end else if ((TIMEOUT > 0) && (wait_cnt == TW'(TLAST))) begin
                    abort      = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs are registered off the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            i_ack_r    <= 1'b0;
            d_ack_r    <= 1'b0;
            err_r      <= 1'b0;
            served_d   <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            mem_req_r <= (state_next == SRV_I) || (state_next == SRV_D);
            busy_r    <= (state_next != IDLE);
            i_ack_r   <= (state_next == ACK) && !served_d;
            d_ack_r   <= (state_next == ACK) && served_d;
            err_r     <= abort;

            if (grant_i || grant_d) begin
                served_d <= grant_d;
                wait_cnt <= '0;
            end else if (in_srv && !bus.mem_ready && (wait_cnt != TW'(TLAST))) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d) begin
                if (!bus.i_req) begin
                    starve_cnt <= '0;
                end else if (!starve_max) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

    // Access is latched on grant so requester inputs are free to move until the ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            i_rdata_r   <= '0;
            d_rdata_r   <= '0;
        end else begin
            if (grant_d) begin
                mem_we_r    <= bus.d_we;
                mem_addr_r  <= bus.d_addr;
                mem_wdata_r <= bus.d_wdata;
            end else if (grant_i) begin
                mem_we_r    <= 1'b0;
                mem_addr_r  <= bus.i_addr;
                mem_wdata_r <= '0;
            end else if (done || abort) begin
                mem_we_r    <= 1'b0;
            end

            if (done) begin
                if (!served_d) begin
                    i_rdata_r <= bus.mem_rdata;
                end else if (!mem_we_r) begin
                    d_rdata_r <= bus.mem_rdata;
                end
            end else if (abort) begin
                if (served_d) begin
                    d_rdata_r <= '0;
                end else begin
                    i_rdata_r <= '0;
                end
            end
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.i_ack     = i_ack_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;

    ack_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.i_ack && bus.d_ack));

    req_only_in_srv: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_req |-> ((state == SRV_I) || (state == SRV_D)));
endmodule
